minibus_ram_slave: RTL and testbench

Minibus slave that terminates the request/response protocol driven by the memory controller. It backs a word-organised single-port RAM. It accepts byte, half-word and word reads and writes, inserts a configurable number of wait states, and returns `ack` with right-aligned read data. It sits on the slave side of the minibus, directly below the memory controller, and serves both instruction fetch and data accesses.

---
 rtl/minibus_ram_slave.sv | 182 ++++++++++++++++++
 tb/tb_minibus_ram_slave.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/minibus_ram_slave.sv
// Minibus RAM slave: single-port word RAM behind the minibus request/response
// protocol. Supports byte/half/word accesses with configurable wait states,
// registered ack/error/rdata, and right-aligned zero-extended read data.
module minibus_ram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_wen,
  input  logic        req_ren,
  input  logic [1:0]  req_width,
  output logic        res_ack,
  output logic        res_error,
  output logic [31:0] res_rdata
);

  localparam int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [33:0] RANGE_BYTES = 34'(DEPTH_WORDS) * 34'd4;
  localparam logic [3:0]  WAIT_LOAD   = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t      state, state_next;
  logic [3:0]  wait_cnt, wait_cnt_next;
  logic        enter_ack;

  logic [31:0] cap_addr, cap_wdata;
  logic [1:0]  cap_width;
  logic        cap_write;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  cur_width;
  logic        cur_write;

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             in_range, misalign, req_err;
  logic [31:0]      ram_word, rd_data, wr_word, wrep;
  logic [3:0]       be;

  // The edge that enters ACK commits the access; with zero wait states that is
  // the capture edge itself, so the live request is used while still in IDLE.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_width = req_width;
      cur_write = req_wen;
    end else begin
      cur_addr  = cap_addr;
      cur_wdata = cap_wdata;
      cur_width = cap_width;
      cur_write = cap_write;
    end
  end

  // Next-state and wait counter logic.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    enter_ack     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_wen || req_ren) begin
          if (WAIT_STATES > 0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = WAIT_LOAD;
          end else begin
            state_next = ST_ACK;
            enter_ack  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = ST_ACK;
          enter_ack  = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Address decode and access checks on the current request.
  always_comb begin
    offset   = cur_addr - ADDR_BASE;
    idx      = offset[IDX_W+1:2];
    lane     = cur_addr[1:0];
    in_range = (cur_addr >= ADDR_BASE) && (34'(offset) < RANGE_BYTES);
    misalign = ((cur_width == 2'b01) && cur_addr[0]) ||
               ((cur_width == 2'b10) && (cur_addr[1:0] != 2'b00));
    req_err  = (cur_width == 2'b11) || misalign || !in_range;
  end

  // Lane select for reads and byte-enable merge for writes.
  always_comb begin
    ram_word = mem[idx];
    rd_data  = '0;
    be       = '0;
    wrep     = cur_wdata;
    case (cur_width)
      2'b00: begin
        rd_data = {24'h0, ram_word[{lane, 3'b000} +: 8]};
        be      = 4'b0001 << lane;
        wrep    = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        rd_data = {16'h0, ram_word[{lane[1], 4'b0000} +: 16]};
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wrep    = {2{cur_wdata[15:0]}};
      end
      2'b10: begin
        rd_data = ram_word;
        be      = '1;
      end
      default: begin
        rd_data = '0;
        be      = '0;
      end
    endcase
    wr_word = ram_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) wr_word[8*i +: 8] = wrep[8*i +: 8];
    end
  end

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Request capture in IDLE; write wins when both enables are set.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && (req_wen || req_ren)) begin
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_width <= req_width;
      cap_write <= req_wen;
    end
  end

  // RAM write on the edge entering ACK; reset in the same cycle discards it.
  always_ff @(posedge clk) begin
    if (!rst && enter_ack && cur_write && !req_err) begin
      mem[idx] <= wr_word;
    end
  end

  // Registered response: ack pulse with error and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_ack   <= 1'b0;
      res_error <= 1'b0;
      res_rdata <= '0;
    end else begin
      res_ack   <= enter_ack;
      res_error <= enter_ack && req_err;
      res_rdata <= (enter_ack && !req_err && !cur_write) ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_minibus_ram_slave.sv
// Bench for minibus_ram_slave: three instances (0, 3 and 4 wait states),
// directed vector table, hand-written timing/reset sequences and randomized
// traffic checked against a byte-addressed reference memory.
module tb_minibus_ram_slave;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned RANGE = DEPTH * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst_s   = '1;
  logic [2:0][31:0]  addr_s  = '0;
  logic [2:0][31:0]  wdata_s = '0;
  logic [2:0]        wen_s   = '0;
  logic [2:0]        ren_s   = '0;
  logic [2:0][1:0]   width_s = '0;
  logic [2:0]        ack_w;
  logic [2:0]        err_w;
  logic [2:0][31:0]  rdata_w;

  minibus_ram_slave #(.ADDR_BASE(32'h0000_0000), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst_s[0]), .req_addr(addr_s[0]), .req_wdata(wdata_s[0]),
    .req_wen(wen_s[0]), .req_ren(ren_s[0]), .req_width(width_s[0]),
    .res_ack(ack_w[0]), .res_error(err_w[0]), .res_rdata(rdata_w[0]));

  minibus_ram_slave #(.ADDR_BASE(32'h0000_1000), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst_s[1]), .req_addr(addr_s[1]), .req_wdata(wdata_s[1]),
    .req_wen(wen_s[1]), .req_ren(ren_s[1]), .req_width(width_s[1]),
    .res_ack(ack_w[1]), .res_error(err_w[1]), .res_rdata(rdata_w[1]));

  minibus_ram_slave #(.ADDR_BASE(32'h0000_0000), .DEPTH_WORDS(DEPTH), .WAIT_STATES(4)) u_ws4 (
    .clk(clk), .rst(rst_s[2]), .req_addr(addr_s[2]), .req_wdata(wdata_s[2]),
    .req_wen(wen_s[2]), .req_ren(ren_s[2]), .req_width(width_s[2]),
    .res_ack(ack_w[2]), .res_error(err_w[2]), .res_rdata(rdata_w[2]));

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] mem_b [3][RANGE];

  function automatic logic [31:0] base_of(input int d);
    return (d == 1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: byte-addressed memory, access of 2**width bytes at an offset.
  task automatic model(input int d, input logic w, input logic [1:0] wd,
                       input logic [31:0] a, input logic [31:0] dt,
                       output logic e, output logic [31:0] rd);
    int unsigned size;
    logic [31:0] off;
    size = 32'd1 << wd;
    off  = a - base_of(d);
    rd   = '0;
    e    = (wd == 2'b11) || (a < base_of(d)) || (off >= RANGE) || ((off % size) != 0);
    if (!e) begin
      for (int i = 0; i < int'(size); i++) begin
        if (w) mem_b[d][int'(off) + i] = dt[8*i +: 8];
        else   rd[8*i +: 8] = mem_b[d][int'(off) + i];
      end
    end
  endtask

  // Drive one request (called at a negedge), hold until ack, then idle a cycle.
  task automatic txn(input int d, input logic w, input logic r, input logic [1:0] wd,
                     input logic [31:0] a, input logic [31:0] dt,
                     output int lat, output logic e, output logic [31:0] rd);
    wen_s[d] = w; ren_s[d] = r; width_s[d] = wd; addr_s[d] = a; wdata_s[d] = dt;
    lat = -1; e = 1'b0; rd = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack_w[d]) begin
        lat = i; e = err_w[d]; rd = rdata_w[d];
        break;
      end
    end
    wen_s[d] = 1'b0; ren_s[d] = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic        wen;
    logic        ren;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int          lat;
    logic        e, me;
    logic [31:0] rd, mrd, a, dt, old;
    logic [1:0]  wd;
    int          k, acks;
    logic [11:0] ack_pat;
    logic [31:0] first_rd;

    tbl.push_back('{"w_word10", 1, 0, 2'd2, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0});
    tbl.push_back('{"r_word10", 0, 1, 2'd2, 32'h10, 32'h0,        0, 1, 32'hDEADBEEF});
    tbl.push_back('{"w_pre20",  1, 0, 2'd2, 32'h20, 32'h11223344, 0, 0, 32'h0});
    tbl.push_back('{"w_byte21", 1, 0, 2'd0, 32'h21, 32'h000000AA, 0, 0, 32'h0});
    tbl.push_back('{"r_word20a",0, 1, 2'd2, 32'h20, 32'h0,        0, 1, 32'h1122AA44});
    tbl.push_back('{"w_half22", 1, 0, 2'd1, 32'h22, 32'h00005566, 0, 0, 32'h0});
    tbl.push_back('{"r_word20b",0, 1, 2'd2, 32'h20, 32'h0,        0, 1, 32'h5566AA44});
    tbl.push_back('{"r_byte23", 0, 1, 2'd0, 32'h23, 32'h0,        0, 1, 32'h00000055});
    tbl.push_back('{"r_half22", 0, 1, 2'd1, 32'h22, 32'h0,        0, 1, 32'h00005566});
    tbl.push_back('{"r_byte20", 0, 1, 2'd0, 32'h20, 32'h0,        0, 1, 32'h00000044});
    tbl.push_back('{"r_mis02",  0, 1, 2'd2, 32'h02, 32'h0,        1, 1, 32'h0});
    tbl.push_back('{"w_pre04",  1, 0, 2'd2, 32'h04, 32'h0BADF00D, 0, 0, 32'h0});
    tbl.push_back('{"w_mis05",  1, 0, 2'd1, 32'h05, 32'h00001234, 1, 0, 32'h0});
    tbl.push_back('{"r_word04", 0, 1, 2'd2, 32'h04, 32'h0,        0, 1, 32'h0BADF00D});
    tbl.push_back('{"r_width3", 0, 1, 2'd3, 32'h08, 32'h0,        1, 1, 32'h0});
    tbl.push_back('{"w_width3", 1, 0, 2'd3, 32'h08, 32'hFFFFFFFF, 1, 0, 32'h0});
    tbl.push_back('{"r_word08", 0, 1, 2'd2, 32'h08, 32'h0,        0, 1, 32'h0});
    tbl.push_back('{"r_oob",    0, 1, 2'd2, 32'h100, 32'h0,       1, 1, 32'h0});
    tbl.push_back('{"w_both30", 1, 1, 2'd2, 32'h30, 32'h0000CAFE, 0, 0, 32'h0});
    tbl.push_back('{"r_word30", 0, 1, 2'd2, 32'h30, 32'h0,        0, 1, 32'h0000CAFE});

    // Reset values.
    rst_s = '1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ack%0d", d),   32'(ack_w[d]), 32'h0);
      chk($sformatf("rst_err%0d", d),   32'(err_w[d]), 32'h0);
      chk($sformatf("rst_rdata%0d", d), rdata_w[d],    32'h0);
    end
    rst_s = '0;
    @(negedge clk);

    // Preload every word so reads are deterministic; word 0x08 on dut0 is zero.
    for (int d = 0; d < 3; d++) begin
      for (int wi = 0; wi < int'(DEPTH); wi++) begin
        a  = base_of(d) + 32'(wi * 4);
        dt = (d == 0 && wi == 2) ? 32'h0 : $urandom;
        model(d, 1'b1, 2'd2, a, dt, me, mrd);
        txn(d, 1'b1, 1'b0, 2'd2, a, dt, lat, e, rd);
        chk($sformatf("pre_lat%0d_%0d", d, wi), 32'(lat), 32'(ws_of(d) + 1));
        chk($sformatf("pre_err%0d_%0d", d, wi), 32'(e), 32'h0);
      end
    end

    // Directed vector table on the zero-wait-state instance.
    foreach (tbl[i]) begin
      model(0, tbl[i].wen, tbl[i].width, tbl[i].addr, tbl[i].wdata, me, mrd);
      txn(0, tbl[i].wen, tbl[i].ren, tbl[i].width, tbl[i].addr, tbl[i].wdata, lat, e, rd);
      chk({tbl[i].name, "_lat"}, 32'(lat), 32'd1);
      chk({tbl[i].name, "_err"}, 32'(e), 32'(tbl[i].exp_err));
      if (tbl[i].chk_rd) chk({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rd);
    end

    // Held read on 3 wait states: acks at cycles 4 and 9, each one cycle wide.
    a = base_of(1) + 32'h10;
    model(1, 1'b0, 2'd2, a, 32'h0, me, mrd);
    wen_s[1] = 1'b0; ren_s[1] = 1'b1; width_s[1] = 2'd2; addr_s[1] = a;
    ack_pat = '0; first_rd = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      ack_pat[c-1] = ack_w[1];
      if (c == 4) first_rd = rdata_w[1];
      if (c == 9) ren_s[1] = 1'b0;
    end
    chk("ws3_ack_pattern", 32'(ack_pat), 32'h108);
    chk("ws3_rdata", first_rd, mrd);

    // Reset during WAIT discards the pending write.
    a = 32'h40;
    model(2, 1'b0, 2'd2, a, 32'h0, me, old);
    wen_s[2] = 1'b1; ren_s[2] = 1'b0; width_s[2] = 2'd2; addr_s[2] = a; wdata_s[2] = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    rst_s[2] = 1'b1; wen_s[2] = 1'b0;
    @(negedge clk);
    chk("rstw_ack", 32'(ack_w[2]), 32'h0);
    rst_s[2] = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack_w[2]) acks++;
    end
    chk("rstw_no_ack", 32'(acks), 32'h0);
    txn(2, 1'b0, 1'b1, 2'd2, a, 32'h0, lat, e, rd);
    chk("rstw_read_lat", 32'(lat), 32'd5);
    chk("rstw_read_old", rd, old);

    // Randomized traffic on dut0 and dut1 against the reference memory.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 200; n++) begin
        k  = int'($urandom_range(0, 2));
        wd = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        if ($urandom_range(0, 7) == 0) a = base_of(d) - $urandom_range(1, 4);
        else a = base_of(d) + $urandom_range(0, RANGE + 7);
        dt = $urandom;
        model(d, (k != 1), wd, a, dt, me, mrd);
        txn(d, (k != 1), (k != 0), wd, a, dt, lat, e, rd);
        chk($sformatf("rnd_lat%0d_%0d", d, n), 32'(lat), 32'(ws_of(d) + 1));
        chk($sformatf("rnd_err%0d_%0d", d, n), 32'(e), 32'(me));
        if (k == 1 || me) chk($sformatf("rnd_rdata%0d_%0d", d, n), rd, mrd);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
